// File: rtl/prefix_pkg.sv
// Shared definitions for the prefix tree: pair-encoding bit positions and level count.
// Supplies default INPUTSIZE/GROUPSIZE when the build does not define them.
`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

package prefix_pkg;

    localparam int G_BIT  = 1;
    localparam int P_BIT  = 0;
    localparam int PAIR_W = 2;

    // Number of up-sweep levels for a tree of n group pairs (n a power of two).
    function automatic int prefix_levels(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/prefix_logic.sv
// Prefix combine cell: r = {gh | (ph & gl), ph & pl}.
// ql is the lower-index node, qh the higher-index node.
module prefix_logic
    import prefix_pkg::*;
(
    input  logic [PAIR_W-1:0] ql,
    input  logic [PAIR_W-1:0] qh,
    output logic [PAIR_W-1:0] r
);

    assign r[G_BIT] = qh[G_BIT] | (qh[P_BIT] & ql[G_BIT]);
    assign r[P_BIT] = qh[P_BIT] & ql[P_BIT];

endmodule

// File: rtl/prefix_tree_first_half_pipe.sv
// Up-sweep (first half) of a parallel-prefix tree with valid/ready handshake.
// Define PREFIX_TREE_PIPE_EN for one register stage per level; otherwise a single output stage.
module prefix_tree_first_half_pipe
    import prefix_pkg::*;
#(
    parameter int Treesize = `INPUTSIZE / `GROUPSIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Treesize*2-1:0] qin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Treesize*2-1:0] q
);

    localparam int W = Treesize * PAIR_W;
    localparam int L = prefix_levels(Treesize);
`ifdef PREFIX_TREE_PIPE_EN
    localparam int NS = L;
`else
    localparam int NS = 1;
`endif

    logic [L-1:0][W-1:0]  lvl_in;
    logic [L-1:0][W-1:0]  lvl_out;
    logic [NS-1:0][W-1:0] stage_d;
    logic [NS-1:0][W-1:0] data_q;
    logic [NS-1:0]        valid_q;
    logic [NS-1:0]        adv;
    logic [NS-1:0]        load_v;

    // Level l updates node j only where j+1 is a multiple of 2^(l+1).
    genvar l, j;
    generate
        for (l = 0; l < L; l++) begin : g_lvl
            for (j = 0; j < Treesize; j++) begin : g_node
                if (((j + 1) % (2 ** (l + 1))) == 0) begin : g_comb
                    prefix_logic u_cell (
                        .ql (lvl_in[l][PAIR_W*(j-2**l) +: PAIR_W]),
                        .qh (lvl_in[l][PAIR_W*j +: PAIR_W]),
                        .r  (lvl_out[l][PAIR_W*j +: PAIR_W])
                    );
                end else begin : g_pass
                    assign lvl_out[l][PAIR_W*j +: PAIR_W] = lvl_in[l][PAIR_W*j +: PAIR_W];
                end
            end
        end

        assign lvl_in[0] = qin;
        for (l = 1; l < L; l++) begin : g_wire
`ifdef PREFIX_TREE_PIPE_EN
            assign lvl_in[l] = data_q[l-1];
`else
            assign lvl_in[l] = lvl_out[l-1];
`endif
        end
    endgenerate

`ifdef PREFIX_TREE_PIPE_EN
    assign stage_d = lvl_out;
`else
    assign stage_d[0] = lvl_out[L-1];
`endif

    // A stage advances unless it and every stage below it are full and the output is stalled.
    always_comb begin
        logic stall;
        adv    = '0;
        load_v = '0;
        stall  = ~out_ready;
        for (int k = NS - 1; k >= 0; k--) begin
            stall  = stall & valid_q[k];
            adv[k] = ~stall;
        end
        load_v[0] = in_valid & in_ready;
        for (int k = 1; k < NS; k++) begin
            load_v[k] = valid_q[k-1];
        end
    end

    assign in_ready  = adv[0] & ~flush & rst_n;
    assign out_valid = valid_q[NS-1];
    assign q         = data_q[NS-1];

    // NOTE: data registers are reset too, since q must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= load_v[k];
                    if (load_v[k]) data_q[k] <= stage_d[k];
                end
            end
        end
    end

endmodule
